// File: rtl/calc_ctrl.sv
// Calculator operation sequencer: debounces the execute/clear buttons, snapshots
// the operands into the ALU, waits a fixed settle time, then writes back to the accumulator.
module calc_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int ALU_WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnd,
  input  logic        btnu,
  input  logic [3:0]  alu_op_in,
  input  logic [15:0] sw,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic [3:0]  alu_op,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [31:0] accum,
  output logic [15:0] led,
  output logic        busy,
  output logic        zero_flag,
  output logic        ovf_flag
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int WW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

  typedef enum logic {IDLE, EXEC} state_t;

  // Index 0 is the execute button (btnd), index 1 the clear button (btnu).
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    evt;
  logic [DW-1:0] deb_cnt [2];

  logic          exec_evt;
  logic          clr_evt;

  state_t        state;
  state_t        next_state;
  logic          load_ops;
  logic          write_back;
  logic [WW-1:0] wait_cnt;

  // A level change is accepted on the DEB_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      stable     <= '0;
      evt        <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= {btnu, btnd};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        evt[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          stable[i]  <= ~stable[i];
          evt[i]     <= ~stable[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign exec_evt = evt[0];
  assign clr_evt  = evt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Clear has priority everywhere; exec is only honoured from IDLE, never queued.
  always_comb begin
    next_state = state;
    load_ops   = 1'b0;
    write_back = 1'b0;
    busy       = (state == EXEC);
    case (state)
      IDLE: begin
        if (clr_evt) begin
          next_state = IDLE;
        end else if (exec_evt) begin
          load_ops   = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (clr_evt) begin
          next_state = IDLE;
        end else if (wait_cnt == '0) begin
          write_back = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op    <= '0;
      op1       <= '0;
      op2       <= '0;
      wait_cnt  <= '0;
      accum     <= '0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      if (load_ops) begin
        alu_op   <= alu_op_in;
        op1      <= accum;
        op2      <= {{16{sw[15]}}, sw};
        wait_cnt <= WW'(ALU_WAIT - 1);
      end else if (state == EXEC && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WW'(1);
      end

      if (clr_evt) begin
        accum     <= '0;
        zero_flag <= 1'b0;
        ovf_flag  <= 1'b0;
      end else if (write_back) begin
        accum     <= alu_result;
        zero_flag <= alu_zero;
        ovf_flag  <= ovf_flag | alu_ovf;
      end
    end
  end

  assign led = accum[15:0];

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: a behavioural ALU drives the DUT, and a window-based
// reference model of debounce plus op sequencing is compared every cycle.
module tb_calc_ctrl;

  localparam int DEB   = 4;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnd = 1'b0;
  logic        btnu = 1'b0;
  logic [3:0]  alu_op_in = 4'h0;
  logic [15:0] sw = 16'h0;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_ovf;
  logic [3:0]  alu_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] accum;
  logic [15:0] led;
  logic        busy;
  logic        zero_flag;
  logic        ovf_flag;

  int checks = 0;
  int failures = 0;
  int busy_cycles = 0;

  calc_ctrl #(.DEB_CYCLES(DEB), .ALU_WAIT(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .btnd(btnd), .btnu(btnu),
    .alu_op_in(alu_op_in), .sw(sw), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_op(alu_op),
    .op1(op1), .op2(op2), .accum(accum), .led(led), .busy(busy),
    .zero_flag(zero_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  // Bench ALU: 2 add, 6 sub, E forces zero, F passes op1 with overflow, else xor.
  function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic        o;
    o = 1'b0;
    case (op)
      4'h2: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      4'h6: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      4'hE: r = 32'h0;
      4'hF: begin r = a; o = 1'b1; end
      default: r = a ^ b;
    endcase
    return {o, r};
  endfunction

  always_comb begin
    {alu_ovf, alu_result} = alu_fn(alu_op, op1, op2);
    alu_zero = (alu_result == 32'h0);
  end

  // Reference model: a button level flips once the last DEB synced samples all
  // disagree with it; an op occupies WAITC cycles after the cycle its event is seen.
  int          m_remain;
  logic [3:0]  m_op;
  logic [31:0] m_op1, m_op2, m_acc;
  logic        m_zf, m_of;
  logic [1:0]  m_evt, m_stab, m_h0, m_h1;
  logic [DEB-1:0] m_win_d, m_win_u;

  always @(posedge clk or negedge rst_n) begin
    logic [32:0] res;
    if (!rst_n) begin
      m_remain = 0; m_op = '0; m_op1 = '0; m_op2 = '0; m_acc = '0;
      m_zf = 1'b0; m_of = 1'b0; m_evt = '0; m_stab = '0; m_h0 = '0; m_h1 = '0;
      m_win_d = '0; m_win_u = '0;
    end else begin
      if (m_evt[1]) begin
        m_acc = '0; m_zf = 1'b0; m_of = 1'b0; m_remain = 0;
      end else if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) begin
          res   = alu_fn(m_op, m_op1, m_op2);
          m_acc = res[31:0];
          m_zf  = (res[31:0] == 32'h0);
          m_of  = m_of | res[32];
        end
      end else if (m_evt[0]) begin
        m_op = alu_op_in; m_op1 = m_acc; m_op2 = {{16{sw[15]}}, sw}; m_remain = WAITC;
      end
      m_evt   = '0;
      m_win_d = {m_win_d[DEB-2:0], m_h1[0]};
      m_win_u = {m_win_u[DEB-2:0], m_h1[1]};
      if (m_win_d == {DEB{~m_stab[0]}}) begin m_stab[0] = ~m_stab[0]; m_evt[0] = m_stab[0]; end
      if (m_win_u == {DEB{~m_stab[1]}}) begin m_stab[1] = ~m_stab[1]; m_evt[1] = m_stab[1]; end
      m_h1 = m_h0;
      m_h0 = {btnu, btnd};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (busy) busy_cycles++;
      checkOutput("busy",      {31'b0, busy},      {31'b0, (m_remain > 0)});
      checkOutput("accum",     accum,              m_acc);
      checkOutput("led",       {16'b0, led},       {16'b0, m_acc[15:0]});
      checkOutput("op1",       op1,                m_op1);
      checkOutput("op2",       op2,                m_op2);
      checkOutput("alu_op",    {28'b0, alu_op},    {28'b0, m_op});
      checkOutput("zero_flag", {31'b0, zero_flag}, {31'b0, m_zf});
      checkOutput("ovf_flag",  {31'b0, ovf_flag},  {31'b0, m_of});
    end
  end

  task automatic applyStimulus(input logic d, input logic u, input int cycles);
    btnd = d;
    btnu = u;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic press(input logic d, input logic u);
    applyStimulus(d, u, 8);
    applyStimulus(1'b0, 1'b0, 10);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("reset_accum", accum, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_op2", op2, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bounces shorter than DEB cycles, then a long hold: exactly one op.
    alu_op_in = 4'h2; sw = 16'h0; busy_cycles = 0;
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("t1_no_op", 32'(busy_cycles), 32'd0);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("t1_one_op", 32'(busy_cycles), 32'd2);
    applyStimulus(1'b1, 1'b0, 20);
    checkOutput("t1_hold_no_repeat", 32'(busy_cycles), 32'd2);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("t1_zero_flag", {31'b0, zero_flag}, 32'd1);

    // Add sequence.
    press(1'b0, 1'b1);
    sw = 16'h0005;
    press(1'b1, 1'b0);
    checkOutput("t2_op1", op1, 32'h0);
    checkOutput("t2_op2", op2, 32'h5);
    checkOutput("t2_accum", accum, 32'h5);
    checkOutput("t2_zero", {31'b0, zero_flag}, 32'd0);
    sw = 16'hFFFF;
    press(1'b1, 1'b0);
    checkOutput("t2_op2_neg", op2, 32'hFFFF_FFFF);
    checkOutput("t2_accum_dec", accum, 32'h4);

    // Bounce during an op, then the fastest legal re-press.
    busy_cycles = 0;
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("t3_single_op", 32'(busy_cycles), 32'd2);
    checkOutput("t3_accum", accum, 32'h3);
    busy_cycles = 0;
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("t3_two_ops", 32'(busy_cycles), 32'd4);
    checkOutput("t3_accum2", accum, 32'h1);

    // Clear one cycle into EXEC, then clear together with exec.
    sw = 16'h0005; busy_cycles = 0;
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 8);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("t4_mid_clear_accum", accum, 32'h0);
    checkOutput("t4_mid_clear_busy", 32'(busy_cycles), 32'd1);
    sw = 16'h0007;
    press(1'b1, 1'b0);
    checkOutput("t4_accum7", accum, 32'h7);
    busy_cycles = 0;
    press(1'b1, 1'b1);
    checkOutput("t4_same_cycle_accum", accum, 32'h0);
    checkOutput("t4_same_cycle_no_op", 32'(busy_cycles), 32'd0);
    checkOutput("t4_op2_kept", op2, 32'h7);

    // Sticky overflow and zero flag.
    alu_op_in = 4'hF;
    press(1'b1, 1'b0);
    checkOutput("t5_ovf_set", {31'b0, ovf_flag}, 32'd1);
    alu_op_in = 4'h2; sw = 16'h0003;
    press(1'b1, 1'b0);
    checkOutput("t5_ovf_sticky", {31'b0, ovf_flag}, 32'd1);
    checkOutput("t5_accum3", accum, 32'h3);
    press(1'b0, 1'b1);
    checkOutput("t5_ovf_cleared", {31'b0, ovf_flag}, 32'd0);
    alu_op_in = 4'hE;
    press(1'b1, 1'b0);
    checkOutput("t5_zero_set", {31'b0, zero_flag}, 32'd1);

    // Asynchronous reset in the middle of EXEC.
    alu_op_in = 4'h2; sw = 16'h0009;
    press(1'b1, 1'b0);
    checkOutput("t6_accum9", accum, 32'h9);
    btnd = 1'b1;
    for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
    checkOutput("t6_busy_seen", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_accum", accum, 32'h0);
    checkOutput("t6_rst_op1", op1, 32'h0);
    checkOutput("t6_rst_op2", op2, 32'h0);
    checkOutput("t6_rst_alu_op", {28'b0, alu_op}, 32'h0);
    checkOutput("t6_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("t6_rst_led", {16'b0, led}, 32'h0);
    checkOutput("t6_rst_flags", {30'b0, zero_flag, ovf_flag}, 32'h0);
    btnd = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sw = 16'h0005;
    press(1'b1, 1'b0);
    checkOutput("t6_after_accum", accum, 32'h5);

    // Randomized button levels and operands against the model.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] ops [5];
      ops = '{4'h2, 4'h6, 4'hE, 4'hF, 4'h3};
      sw = 16'($urandom);
      alu_op_in = ops[$urandom_range(0, 4)];
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                    $urandom_range(1, 10));
    end
    applyStimulus(1'b0, 1'b0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
